multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM sequencing a multicycle RV32I subset datapath: shared instr/data memory, IR, OldPC, ALUOut, Data regs.
//  Supersedes the combinational decoder for the multicycle core.
//  Supports lw, sw, R-type (add/sub/slt/or/and), addi-class (addi/slti/ori/andi), beq, jal.
//  Inserts a parameterised wait for the synchronous memory.
// PARAMETERS
//  MEM_WAIT  1  extra cycles held in FETCH and MEMREAD before memory read data is valid (0..3)
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high; state -> FETCH, wait_cnt -> 0
//  op           in   7  IR[6:0]
//  funct3       in   3  IR[14:12]
//  funct7b5     in   1  IR[30]
//  zero         in   1  ALU zero flag, same cycle
//  pc_write     out  1  PC load enable
//  adr_src      out  1  memory address: 0=PC, 1=ALUOut
//  mem_write    out  1  memory write enable
//  ir_write     out  1  IR and OldPC load enable
//  reg_write    out  1  register file write enable
//  result_src   out  2  00=ALUOut, 01=Data, 10=ALU result
//  alu_src_a    out  2  00=PC, 01=OldPC, 10=rs1
//  alu_src_b    out  2  00=rs2, 01=imm_ext, 10=constant 4
//  alu_control  out  3  000 add, 001 sub, 101 slt, 011 or, 010 and
//  imm_src      out  2  00 I, 01 S, 10 B, 11 J
//  illegal      out  1  high while in TRAP
//  state_debug  out  4  current state code
// BEHAVIOUR
//  State codes:
//    FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6,
//    EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=15.
//  Output defaults: every enable 0; all 2/3-bit selects 0.
//  During reset: state=FETCH; pc_write, ir_write, reg_write, mem_write forced 0; other outputs show FETCH decode.
//  wait_cnt: counts 0..MEM_WAIT in FETCH and MEMREAD; cleared on leaving either state.
//  FETCH:
//    adr_src=0, a=00, b=10, add, result_src=10.
//    Stays while wait_cnt<MEM_WAIT. On the final cycle: ir_write=1, pc_write=1 (PC<=PC+4), -> DECODE.
//  DECODE:
//    a=01, b=01, add; imm_src=11 if op=1101111, else 10 (target into ALUOut).
//    Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI;
//    1100011 -> BEQ; 1101111 -> JAL; anything else -> TRAP.
//    Unsupported funct3 for R/I-type, and funct3!=000 for beq -> TRAP.
//  MEMADR: a=10, b=01, add; imm_src=00 (lw) or 01 (sw). -> MEMREAD if op[5]=0, else MEMWRITE.
//  MEMREAD: adr_src=1, result_src=00. Stays MEM_WAIT extra cycles, then -> MEMWB.
//  MEMWB: result_src=01, reg_write=1, -> FETCH.
//  MEMWRITE: adr_src=1, result_src=00, mem_write=1 for exactly one cycle, -> FETCH.
//  EXECR:
//    a=10, b=00, -> ALUWB.
//    funct3 000: add if funct7b5=0, else sub. 010 slt. 110 or. 111 and.
//  EXECI: a=10, b=01, imm_src=00, -> ALUWB. funct3 as for EXECR; funct7b5 ignored (000 always add).
//  ALUWB: result_src=00, reg_write=1, -> FETCH.
//  BEQ: a=10, b=00, sub, result_src=00; pc_write=zero (PC<=ALUOut); -> FETCH.
//  JAL: a=01, b=10, add, result_src=00, pc_write=1 (PC<=target); -> ALUWB (rd<=OldPC+4).
//  TRAP: all enables 0, illegal=1. Absorbing; exits only via reset.
//  Cycle counts (W=MEM_WAIT): beq 3+W, sw/R/I/jal 4+W, lw 5+2W.
//  Write enables are single-cycle pulses; never two of pc_write/mem_write/reg_write high in MEMWRITE/MEMWB/ALUWB.
//  Reset asserted mid-instruction: immediate return to FETCH with wait_cnt=0; no partial write occurs after release.
// TESTING
//  T1 reset held 3 cycles, released -> state_debug=0; pc_write and ir_write stay 0 until the cycle after release;
//     with MEM_WAIT=1, ir_write pulses on the 2nd FETCH cycle.
//  T2 lw: op=0000011, MEM_WAIT=1 -> states 0,0,1,2,3,3,4; reg_write=1 only in 4 with result_src=01; 7 cycles total.
//  T3 sw: op=0100011 -> MEMADR imm_src=01; MEMWRITE mem_write=1, adr_src=1 exactly one cycle; reg_write never high.
//  T4 R-type: funct3=000, funct7b5=1 -> EXECR alu_control=001.
//     Repeat with funct3=110 -> 011, funct3=111 -> 010, funct3=010 -> 101.
//     EXECI with funct7b5=1, funct3=000 -> 000.
//  T5 beq:
//     zero=1 in BEQ -> pc_write=1; zero=0 -> pc_write=0; next state FETCH either way.
//     jal -> JAL pc_write=1, then ALUWB reg_write=1.
//  T6 op=1111111 or R-type funct3=001 -> TRAP, illegal=1, state_debug=15 for 10+ cycles;
//     reset asserted during MEMREAD -> FETCH same cycle, no reg_write.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore FSM that sequences a multicycle RV32I-subset datapath built around
//   a shared instruction/data memory and the IR, OldPC, ALUOut and Data
//   holding registers. Handles lw, sw, R-type (add/sub/slt/or/and),
//   I-type ALU (addi/slti/ori/andi), beq and jal. Anything else parks the
//   FSM in TRAP until reset.
//
//   MEM_WAIT extra cycles are spent in FETCH and MEMREAD so a synchronous
//   memory has its read data ready before IR / Data capture it.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high
//   op           in   IR[6:0]
//   funct3       in   IR[14:12]
//   funct7b5     in   IR[30]
//   zero         in   ALU zero flag (same cycle)
//   pc_write     out  PC load enable
//   adr_src      out  memory address select: 0=PC, 1=ALUOut
//   mem_write    out  memory write enable
//   ir_write     out  IR / OldPC load enable
//   reg_write    out  register file write enable
//   result_src   out  00=ALUOut, 01=Data, 10=ALU result
//   alu_src_a    out  00=PC, 01=OldPC, 10=rs1
//   alu_src_b    out  00=rs2, 01=imm_ext, 10=constant 4
//   alu_control  out  000 add, 001 sub, 101 slt, 011 or, 010 and
//   imm_src      out  00 I, 01 S, 10 B, 11 J
//   illegal      out  high while in TRAP
//   state_debug  out  current state code
module multicycle_controller #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic [3:0] state_debug
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b010;

  localparam logic [1:0] WAIT_MAX = 2'(MEM_WAIT);

  logic [3:0] state, state_nx;
  logic [1:0] wait_cnt;
  logic       wait_done;
  logic       funct3_ok;
  logic [2:0] alu_fn;

  // raw enables before reset gating
  logic pc_write_c, mem_write_c, ir_write_c, reg_write_c;

  assign wait_done = (wait_cnt == WAIT_MAX);

  // funct3 values the R/I ALU path can execute
  assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  // ALU op for EXECR/EXECI; funct7b5 selects sub only for register ops,
  // since for addi IR[30] is just an immediate bit.
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:   state_nx = wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_RTYPE:          state_nx = funct3_ok ? S_EXECR : S_TRAP;
          OP_ITYPE:          state_nx = funct3_ok ? S_EXECI : S_TRAP;
          OP_BEQ:            state_nx = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
          OP_JAL:            state_nx = S_JAL;
          default:           state_nx = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nx = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nx = wait_done ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: state_nx = S_FETCH;
      S_EXECR:    state_nx = S_ALUWB;
      S_EXECI:    state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BEQ:      state_nx = S_FETCH;
      S_JAL:      state_nx = S_ALUWB;
      S_TRAP:     state_nx = S_TRAP;
      // unused encodings are treated as a fault and parked in TRAP
      default:    state_nx = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Wait counter runs only inside the two memory-read states and restarts
  // from zero every time one of them is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= 2'd0;
    else if ((state == S_FETCH || state == S_MEMREAD) && !wait_done)
      wait_cnt <= wait_cnt + 2'd1;
    else
      wait_cnt <= 2'd0;
  end

  // Moore outputs
  always_comb begin
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = 2'b00;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // capture only once memory data is valid; PC+4 goes straight to PC
        ir_write_c = wait_done;
        pc_write_c = wait_done;
      end
      S_DECODE: begin
        // precompute branch/jump target into ALUOut from OldPC
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_JAL) ? 2'b11 : 2'b10;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op[5] ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        result_src  = 2'b00;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = alu_fn;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        imm_src     = 2'b00;
        alu_control = alu_fn;
      end
      S_ALUWB: begin
        result_src  = 2'b00;
        reg_write_c = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = ALU_SUB;
        result_src  = 2'b00;
        pc_write_c  = zero;
      end
      S_JAL: begin
        // PC <= target held in ALUOut while the ALU forms OldPC+4 for rd
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b00;
        pc_write_c = 1'b1;
      end
      S_TRAP: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // With MEM_WAIT=0 FETCH would raise ir/pc write combinationally while
  // reset is still high, so every enable is gated by reset.
  assign pc_write    = pc_write_c  & ~reset;
  assign mem_write   = mem_write_c & ~reset;
  assign ir_write    = ir_write_c  & ~reset;
  assign reg_write   = reg_write_c & ~reset;
  assign state_debug = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. A driver issues instructions
// and pushes the expected per-cycle output trace, built from the instruction
// class's documented phase list, into a queue; a monitor pops one entry per
// cycle on the falling edge and compares.
module tb_multicycle_controller;

  localparam int W = 1;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] res, a, b;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_debug;

  multicycle_controller #(.MEM_WAIT(W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .illegal(illegal), .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  exp_t act;
  assign act = '{state_debug, pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};

  exp_t sb[$];
  exp_t tr[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   step = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  function automatic exp_t mk(input logic [3:0] st, input logic pcw, adr, mw, irw, rw,
                              input logic [1:0] res, a, b, input logic [2:0] alu,
                              input logic [1:0] imm, input logic ill);
    exp_t e;
    e = '{st, pcw, adr, mw, irw, rw, res, a, b, alu, imm, ill};
    return e;
  endfunction

  function automatic logic alu_legal(input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  // add/sub/slt/or/and codes from funct3 (sub only for register ops)
  function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'd0: return (is_r && f7) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t rst_rec();
    return mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 1'b0);
  endfunction

  // Expected trace for one instruction: fetch phase (1+W cycles), decode,
  // then the class-specific phases; illegal encodings end in 12 TRAP cycles.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    logic trap;
    tr.delete();
    for (int i = 0; i <= W; i++)
      tr.push_back(mk(4'd0, i == W, 1'b0, 1'b0, i == W, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 1'b0));
    tr.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 3'd0,
                    (o == JL) ? 2'd3 : 2'd2, 1'b0));
    trap = 1'b0;
    case (o)
      LW: begin
        tr.push_back(mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0));
        for (int i = 0; i <= W; i++)
          tr.push_back(mk(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0));
        tr.push_back(mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0));
      end
      SW: begin
        tr.push_back(mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd1, 1'b0));
        tr.push_back(mk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0));
      end
      RT, IT: begin
        if (!alu_legal(f3)) trap = 1'b1;
        else begin
          if (o == RT)
            tr.push_back(mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, alu_exp(f3, f7, 1'b1), 2'd0, 1'b0));
          else
            tr.push_back(mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, alu_exp(f3, f7, 1'b0), 2'd0, 1'b0));
          tr.push_back(mk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0));
        end
      end
      BQ: begin
        if (f3 != 3'd0) trap = 1'b1;
        else tr.push_back(mk(4'd9, z, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd1, 2'd0, 1'b0));
      end
      JL: begin
        tr.push_back(mk(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, 2'd0, 1'b0));
        tr.push_back(mk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0));
      end
      default: trap = 1'b1;
    endcase
    if (trap)
      for (int i = 0; i < 12; i++)
        tr.push_back(mk(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1));
  endtask

  // Called at posedge+1: hold reset for n cycles, one expected entry each.
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) sb.push_back(rst_rec());
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Called at posedge+1 with the DUT at the start of FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    build(o, f3, f7, z);
    foreach (tr[i]) sb.push_back(tr[i]);
    repeat (tr.size()) @(posedge clk);
    #1;
    if (tr[tr.size()-1].st == 4'd15) do_reset(2);
  endtask

  // lw interrupted by reset in its first MEMREAD cycle
  task automatic lw_reset_in_memread();
    op = LW; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
    build(LW, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < W + 4; i++) sb.push_back(tr[i]);
    repeat (W + 3) @(posedge clk);
    #1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (state_debug !== 4'd0 || reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_in_memread: state=%0d reg_write=%b, want state=0 reg_write=0",
               state_debug, reg_write);
    end
    sb.push_back(rst_rec());
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL cycle_step %0d: got st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b res=%0d a=%0d b=%0d alu=%0d imm=%0d ill=%b | want st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b res=%0d a=%0d b=%0d alu=%0d imm=%0d ill=%b",
                 step, act.st, act.pcw, act.adr, act.mw, act.irw, act.rw, act.res, act.a, act.b,
                 act.alu, act.imm, act.ill, e.st, e.pcw, e.adr, e.mw, e.irw, e.rw, e.res, e.a,
                 e.b, e.alu, e.imm, e.ill);
      end
      step++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] o;
    logic [2:0] f3;
    int cls;
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1 do_reset(3);

    // directed
    run_instr(LW, 3'd2, 1'b0, 1'b0);
    run_instr(SW, 3'd2, 1'b0, 1'b1);
    run_instr(RT, 3'd0, 1'b1, 1'b0);
    run_instr(RT, 3'd6, 1'b0, 1'b0);
    run_instr(RT, 3'd7, 1'b0, 1'b0);
    run_instr(RT, 3'd2, 1'b0, 1'b0);
    run_instr(IT, 3'd0, 1'b1, 1'b0);
    run_instr(BQ, 3'd0, 1'b0, 1'b1);
    run_instr(BQ, 3'd0, 1'b0, 1'b0);
    run_instr(JL, 3'd3, 1'b1, 1'b0);
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0);
    run_instr(RT, 3'd1, 1'b0, 1'b0);
    run_instr(BQ, 3'd1, 1'b0, 1'b1);
    lw_reset_in_memread();
    run_instr(IT, 3'd6, 1'b0, 1'b0);

    // random
    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 7);
      f3 = 3'($urandom_range(0, 7));
      case (cls)
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: begin o = BQ; f3 = 3'd0; end
        5: o = JL;
        6: o = 7'($urandom_range(0, 127));
        default: o = BQ;
      endcase
      if ((cls == 2 || cls == 3) && $urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 3))
          0: f3 = 3'd0;
          1: f3 = 3'd2;
          2: f3 = 3'd6;
          default: f3 = 3'd7;
        endcase
      end
      if (cls == 1 && $urandom_range(0, 3) == 0) lw_reset_in_memread();
      else run_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
